dd_bcd_conv_arbiter: RTL and testbench
======================================

DD_BCD_CONV_ARBITER -- requirements
Module: dd_bcd_conv_arbiter

Interface
REQ-001 Parameter WID, default 128: binary result width; SHALL match the shared converter's WID.
REQ-002 Parameter NREQ, default 4: number of requesters, 2..16.
REQ-003 Parameter TMO, default 255: maximum cycles in BUSY before timeout, 1..65535.
REQ-004 Localparam BCDWID SHALL equal ((WID+(WID-4)/3)+3) & -4, and IDW SHALL equal clog2(NREQ).
REQ-005 clk  in  1  clock; all logic rising-edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 req  in  NREQ  per-requester level request; held until granted.
REQ-008 req_bcd  in  NREQ*BCDWID  packed operands; requester i occupies bits [i*BCDWID +: BCDWID].
REQ-009 gnt  out  NREQ  one-hot, single-cycle acceptance pulse.
REQ-010 resp_valid  out  1  result available.
REQ-011 resp_ready  in  1  consumer accepts result.
REQ-012 resp_id  out  IDW  index of the requester that owns the result.
REQ-013 resp_bin  out  WID  converted binary value.
REQ-014 resp_err  out  1  result invalid because of timeout; qualified by resp_valid.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 conv_ld  out  1  load strobe to the converter.
REQ-017 conv_bcd  out  BCDWID  operand to the converter.
REQ-018 conv_bin  in  WID  converter result.
REQ-019 conv_done  in  1  converter done; high while the converter is idle, low during conversion.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, WAIT0, BUSY and RESP, and no others.
REQ-021 IDLE with req!=0: select the first set req bit scanning upward from ptr+1 modulo NREQ, pulse its gnt, latch its req_bcd into conv_bcd and its index into resp_id, set ptr to that index, then go to LOAD.
REQ-022 IDLE with req==0: gnt SHALL be 0 and the FSM SHALL stay in IDLE.
REQ-023 LOAD: conv_ld=1 for exactly this one cycle, then go to WAIT0.
REQ-024 WAIT0: ignore conv_done for one cycle, because the converter still reports its stale done=1, then go to BUSY with the timeout counter cleared.
REQ-025 BUSY, conv_done=1: latch conv_bin into resp_bin, clear resp_err, set resp_valid, and go to RESP.
REQ-026 BUSY, conv_done=0: increment the timeout counter.
REQ-027 BUSY, counter reaches TMO before done: set resp_bin=0, resp_err=1 and resp_valid=1, and go to RESP.
REQ-028 RESP: hold resp_valid, resp_id, resp_bin and resp_err stable until resp_ready=1.
REQ-029 In the cycle resp_valid and resp_ready are both 1, clear resp_valid and go to IDLE.
REQ-030 Arbitration SHALL NOT occur in that handshake cycle; the earliest next gnt is the cycle after.
REQ-031 conv_bcd SHALL remain stable from LOAD until the next grant.
REQ-032 conv_ld SHALL be 0 in every state except LOAD.
REQ-033 At most one conversion SHALL be outstanding at any time.
REQ-034 req changes outside IDLE SHALL have no effect.
REQ-035 gnt SHALL never have more than one bit set.
REQ-036 Fairness: a continuously asserted request SHALL be granted within NREQ grants.
REQ-037 Minimum grant-to-resp_valid latency SHALL be 3 cycles plus the converter latency, which is (WID+DEP-1)/DEP+2 cycles after conv_ld.
REQ-038 An illegal state encoding SHALL return to IDLE with resp_valid=0.

Reset
REQ-039 While rst=1: state=IDLE, ptr=NREQ-1, gnt=0, resp_valid=0, resp_err=0, resp_id=0, resp_bin=0, conv_ld=0, conv_bcd=0, busy=0, timeout counter=0.
REQ-040 rst asserted in any state, including BUSY mid-conversion, SHALL abandon the transaction with no resp_valid.
REQ-041 Because rst is shared with the converter, the first grant after reset SHALL go to requester 0 when req[0]=1.

Verification (WID=16 so BCDWID=20, NREQ=4, converter DEP=2)
REQ-042 Single request: req=4'b0001 with req_bcd[19:0]=20'h01234 -> gnt=0001 for one cycle, conv_ld one cycle later, then resp_valid with resp_id=0, resp_bin=16'h04D2, resp_err=0.
REQ-043 Round robin: req=4'b1111 held with resp_ready=1 -> grant order 0,1,2,3,0.
REQ-044 Round robin continued: after a grant to 2, req=4'b0101 -> next grant goes to 0.
REQ-045 Backpressure: resp_ready=0 for 10 cycles while resp_valid=1 -> outputs stay stable, gnt=0 and conv_ld=0 throughout; resp_ready=1 -> IDLE the next cycle.
REQ-046 Timeout: TMO=20 with a converter stub that holds conv_done=0 after ld -> resp_valid with resp_err=1 and resp_bin=0, 20 cycles after entering BUSY.
REQ-047 Reset mid-BUSY: assert rst in BUSY -> no resp_valid, busy=0 next cycle; a following req[3] with 20'h65535 -> resp_bin=16'hFFFF, resp_id=3.

Source files
------------

// File: rtl/dd_bcd_conv_arbiter.sv
// rtl/dd_bcd_conv_arbiter.sv - round-robin arbiter sharing one BCD-to-binary converter
// Grants one requester at a time, drives the converter and returns its result with a timeout guard.
module dd_bcd_conv_arbiter #(
  parameter int WID  = 128,
  parameter int NREQ = 4,
  parameter int TMO  = 255,
  localparam int BCDWID = ((WID + (WID - 4) / 3) + 3) & -4,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*BCDWID-1:0]   req_bcd,
  output logic [NREQ-1:0]          gnt,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [IDW-1:0]           resp_id,
  output logic [WID-1:0]           resp_bin,
  output logic                     resp_err,
  output logic                     busy,
  output logic                     conv_ld,
  output logic [BCDWID-1:0]        conv_bcd,
  input  logic [WID-1:0]           conv_bin,
  input  logic                     conv_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WAIT0 = 3'd2,
    BUSY  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t              state_q;
  logic [IDW-1:0]      ptr_q;
  logic [15:0]         tmo_q;
  logic                resp_valid_q;
  logic                resp_err_q;
  logic [IDW-1:0]      resp_id_q;
  logic [WID-1:0]      resp_bin_q;
  logic [BCDWID-1:0]   conv_bcd_q;

  logic                sel_found;
  logic [IDW-1:0]      sel_idx;
  logic [NREQ-1:0]     sel_oh;
  logic [IDW:0]        scan;
  logic [BCDWID-1:0]   sel_bcd;

  // Rotating priority: the requester just after the last winner is looked at first.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_oh    = '0;
    scan      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan = {1'b0, ptr_q} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(NREQ)) begin
        scan = scan - (IDW+1)'(NREQ);
      end
      if (!sel_found && req[scan[IDW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = scan[IDW-1:0];
      end
    end
    sel_oh[sel_idx] = sel_found;
    sel_bcd = req_bcd[sel_idx*BCDWID +: BCDWID];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= IDW'(NREQ - 1);
      tmo_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_id_q    <= '0;
      resp_bin_q   <= '0;
      conv_bcd_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            conv_bcd_q <= sel_bcd;
            resp_id_q  <= sel_idx;
            ptr_q      <= sel_idx;
            state_q    <= LOAD;
          end
        end
        LOAD: state_q <= WAIT0;
        // The converter still shows its previous done flag here.
        WAIT0: begin
          tmo_q   <= '0;
          state_q <= BUSY;
        end
        BUSY: begin
          if (conv_done) begin
            resp_bin_q   <= conv_bin;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else if (tmo_q == 16'(TMO - 1)) begin
            resp_bin_q   <= '0;
            resp_err_q   <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  // Grant is the acceptance strobe of the IDLE cycle; everything else comes from registers.
  assign gnt        = (!rst && state_q == IDLE) ? sel_oh : '0;
  assign conv_ld    = !rst && state_q == LOAD;
  assign busy       = !rst && state_q != IDLE;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_id    = resp_id_q;
  assign resp_bin   = resp_bin_q;
  assign conv_bcd   = conv_bcd_q;

endmodule

// File: tb/tb_dd_bcd_conv_arbiter.sv
// tb/tb_dd_bcd_conv_arbiter.sv - scoreboard bench for dd_bcd_conv_arbiter
// Drives requesters against a converter stub and checks grants and responses against a reference model.
module tb_dd_bcd_conv_arbiter;
  localparam int WID    = 16;
  localparam int NREQ   = 4;
  localparam int TMO    = 20;
  localparam int BCDW   = 20;
  localparam int CLAT   = (WID + 2 - 1) / 2 + 2;
  localparam int LAT_OK = 3 + CLAT;
  localparam int LAT_TO = 3 + TMO;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*BCDW-1:0] req_bcd;
  logic [NREQ-1:0]   gnt;
  logic              resp_valid;
  logic              resp_ready;
  logic [1:0]        resp_id;
  logic [WID-1:0]    resp_bin;
  logic              resp_err;
  logic              busy;
  logic              conv_ld;
  logic [BCDW-1:0]   conv_bcd;
  logic [WID-1:0]    conv_bin;
  logic              conv_done;

  dd_bcd_conv_arbiter #(.WID(WID), .NREQ(NREQ), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_bcd(req_bcd), .gnt(gnt),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_bin(resp_bin), .resp_err(resp_err), .busy(busy), .conv_ld(conv_ld),
    .conv_bcd(conv_bcd), .conv_bin(conv_bin), .conv_done(conv_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  function automatic logic [19:0] enc(input int v);
    logic [19:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < 5; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] dec(input logic [19:0] b);
    int v;
    v = 0;
    for (int d = 4; d >= 0; d--) v = v * 10 + int'(b[d*4 +: 4]);
    return 16'(v);
  endfunction

  // Converter stub: decimal decode, fixed latency, or frozen when stalled.
  logic [WID-1:0] stub_bin;
  logic           stub_done;
  logic [3:0]     stub_cnt;
  logic           stub_stall;
  logic           stall;
  always @(posedge clk) begin
    if (rst) begin
      stub_done  <= 1'b1;
      stub_bin   <= '0;
      stub_cnt   <= '0;
      stub_stall <= 1'b0;
    end else if (conv_ld) begin
      stub_done  <= 1'b0;
      stub_cnt   <= 4'(CLAT - 1);
      stub_bin   <= dec(conv_bcd);
      stub_stall <= stall;
    end else if (!stub_done && !stub_stall) begin
      if (stub_cnt == 0) stub_done <= 1'b1;
      else stub_cnt <= stub_cnt - 4'd1;
    end
  end
  assign conv_bin  = stub_bin;
  assign conv_done = stub_done;

  typedef struct { int id; int bin; int err; int gcyc; int lat; } exp_t;
  exp_t sb[$];
  int   glog[$];

  logic [3:0]  pending = '0;
  logic [3:0]  hold = '0;
  int          val[4];
  int          val_a[4];
  int          mptr = 3;
  bit          outstanding = 0;
  bit          ld_exp = 0;
  int          ready_mode = 0;
  logic        rst_next = 1'b0;
  logic [19:0] last_bcd = '0;

  function automatic int pick(input int p, input logic [3:0] pend);
    for (int k = 1; k <= NREQ; k++) begin
      if (pend[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic step();
    logic [3:0] eg;
    int id;
    @(negedge clk);
    id = pick(mptr, req);
    eg = (rst || outstanding || id < 0) ? 4'b0 : 4'(1 << id);
    chk("gnt", 32'(gnt), 32'(eg));
    chk("conv_ld", 32'(conv_ld), 32'(ld_exp));
    if (!rst) chk("conv_bcd_stable", 32'(conv_bcd), 32'(last_bcd));
    ld_exp = (eg != 0);
    if (eg != 0) begin
      sb.push_back('{id, stall ? 0 : val_a[id], int'(stall), cyc, stall ? LAT_TO : LAT_OK});
      glog.push_back(id);
      last_bcd = enc(val_a[id]);
      mptr = id;
      outstanding = 1;
      if (hold[id]) val[id] = $urandom_range(0, 65535);
      else pending[id] = 1'b0;
    end
    if (resp_valid && resp_ready) outstanding = 0;
    if (rst) begin
      sb.delete();
      outstanding = 0;
      mptr = 3;
      ld_exp = 0;
      last_bcd = '0;
    end
    @(posedge clk);
    #1;
    rst = rst_next;
    req = pending;
    for (int i = 0; i < NREQ; i++) begin
      val_a[i] = val[i];
      req_bcd[i*BCDW +: BCDW] = enc(val[i]);
    end
    resp_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((pending != 0 || req != 0 || outstanding || sb.size() != 0) && k < 2000) begin
      step();
      k++;
    end
    if (k >= 2000) bound_fail("drain");
  endtask

  // Response monitor: pops the scoreboard whenever a new result is presented.
  bit pv = 0, post_hs = 0;
  logic [1:0] p_id;
  logic [WID-1:0] p_bin;
  logic p_err;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0;
        post_hs = 0;
      end else begin
        if (post_hs) begin
          chk("busy_after_hs", 32'(busy), 32'd0);
          chk("valid_after_hs", 32'(resp_valid), 32'd0);
        end
        chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
        if (resp_valid) begin
          chk("gnt_in_resp", 32'(gnt), 32'd0);
          chk("ld_in_resp", 32'(conv_ld), 32'd0);
        end
        if (resp_valid && !pv) begin
          if (sb.size() == 0) begin
            bound_fail("unexpected_resp");
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("resp_id", 32'(resp_id), 32'(e.id));
            chk("resp_bin", 32'(resp_bin), 32'(e.bin));
            chk("resp_err", 32'(resp_err), 32'(e.err));
            chk("resp_latency", 32'(cyc - e.gcyc), 32'(e.lat));
          end
        end else if (resp_valid && pv) begin
          chk("hold_id", 32'(resp_id), 32'(p_id));
          chk("hold_bin", 32'(resp_bin), 32'(p_bin));
          chk("hold_err", 32'(resp_err), 32'(p_err));
        end
        pv = resp_valid;
        p_id = resp_id;
        p_bin = resp_bin;
        p_err = resp_err;
        post_hs = resp_valid && resp_ready;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n;
    int exp_o[5];
    exp_o = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NREQ; i++) begin
      val[i] = 0;
      val_a[i] = 0;
    end
    rst = 1'b1;
    req = '0;
    req_bcd = '0;
    resp_ready = 1'b0;
    stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_id", 32'(resp_id), 32'd0);
    chk("rst_bin", 32'(resp_bin), 32'd0);
    chk("rst_ld", 32'(conv_ld), 32'd0);
    chk("rst_bcd", 32'(conv_bcd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    resp_ready = 1'b1;

    // All four held: rotation starting at requester 0.
    for (int i = 0; i < NREQ; i++) val[i] = $urandom_range(0, 65535);
    hold = 4'hF;
    pending = 4'hF;
    k = 0;
    while (glog.size() < 5 && k < 500) begin
      step();
      k++;
    end
    if (glog.size() < 5) bound_fail("rr_grants");
    hold = 4'h0;
    pending = 4'h0;
    drain();
    for (int i = 0; i < 5; i++) chk("rr_order", 32'(glog[i]), 32'(exp_o[i]));

    // Single request, decimal 1234.
    val[0] = 1234;
    pending = 4'b0001;
    drain();
    chk("single_id", 32'(glog[glog.size()-1]), 32'd0);

    // After a grant to 2, 0101 goes to 0 next.
    val[2] = $urandom_range(0, 65535);
    pending = 4'b0100;
    drain();
    n = glog.size();
    val[0] = $urandom_range(0, 65535);
    val[2] = $urandom_range(0, 65535);
    pending = 4'b0101;
    drain();
    chk("rr_after2", 32'(glog[n]), 32'd0);

    // Backpressure with a competing request waiting.
    ready_mode = 2;
    val[1] = $urandom_range(0, 65535);
    pending = 4'b0010;
    k = 0;
    while (!resp_valid && k < 100) begin
      step();
      k++;
    end
    if (!resp_valid) bound_fail("bp_valid");
    val[3] = $urandom_range(0, 65535);
    pending[3] = 1'b1;
    repeat (10) step();
    ready_mode = 0;
    drain();

    // Timeout with a stalled converter.
    stall = 1'b1;
    val[1] = 4321;
    pending = 4'b0010;
    drain();
    stall = 1'b0;

    // Reset in the middle of a conversion.
    n = glog.size();
    val[2] = 777;
    pending = 4'b0100;
    k = 0;
    while (glog.size() == n && k < 100) begin
      step();
      k++;
    end
    if (glog.size() == n) bound_fail("rst_grant");
    repeat (5) step();
    rst_next = 1'b1;
    step();
    rst_next = 1'b0;
    step();
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_valid", 32'(resp_valid), 32'd0);
    val[3] = 65535;
    pending = 4'b1000;
    drain();
    chk("post_rst_id", 32'(glog[glog.size()-1]), 32'd3);

    // Random traffic with random backpressure.
    ready_mode = 1;
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        int j;
        j = $urandom_range(0, 3);
        if (!pending[j]) begin
          val[j] = $urandom_range(0, 65535);
          pending[j] = 1'b1;
        end
      end
      step();
    end
    ready_mode = 0;
    drain();
    repeat (3) step();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
